// File: rtl/RecorderPkg.sv
`default_nettype none
// =============================================================================
// Package : RecorderPkg
// Shared state, event-code and speed definitions for the recorder sequencer
// and the event producer that drives it.
// Rev     : 1.0
// =============================================================================
package RecorderPkg;

   localparam int ADDR_W = 20;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_RECORD = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SPD_NORMAL = 2'd0,
      SPD_FAST   = 2'd1,
      SPD_SLOW   = 2'd2
   } speed_e;

   typedef enum logic [3:0] {
      CODE_NONE   = 4'd0,
      CODE_PLAY   = 4'd1,
      CODE_PAUSE  = 4'd2,
      CODE_STOP   = 4'd3,
      CODE_RECORD = 4'd4
   } code_e;

   localparam int c_ev_code_msb  = 15;
   localparam int c_ev_code_lsb  = 12;
   localparam int c_ev_speed_msb = 11;
   localparam int c_ev_speed_lsb = 10;
   localparam int c_ev_param_msb = 9;
   localparam int c_ev_param_lsb = 6;
   localparam int c_ev_interpol  = 5;

   function automatic speed_e decode_speed(input logic [1:0] raw);
      case (raw)
         2'd1:    decode_speed = SPD_FAST;
         2'd2:    decode_speed = SPD_SLOW;
         default: decode_speed = SPD_NORMAL;
      endcase
   endfunction

   function automatic logic [3:0] decode_factor(input logic [2:0] raw);
      decode_factor = {1'b0, raw} + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/recorder_addr_step.sv
`default_nettype none
// =============================================================================
// Module : recorder_addr_step
// Next sample address and slow-repeat phase after a completed SRAM access.
// Rev    : 1.0
// =============================================================================
module recorder_addr_step
   import RecorderPkg::*;
(
   input  logic              i_play,
   input  logic [ADDR_W-1:0] i_addr,
   input  speed_e            i_speed,
   input  logic [3:0]        i_factor,
   input  logic [2:0]        i_phase,
   output logic [ADDR_W:0]   o_next_addr,
   output logic [2:0]        o_next_phase
);

   always_comb begin
      o_next_addr  = {1'b0, i_addr} + {{ADDR_W{1'b0}}, 1'b1};
      o_next_phase = 3'd0;
      if (i_play) begin
         if (i_speed == SPD_FAST) begin
            o_next_addr = {1'b0, i_addr} + {{(ADDR_W-3){1'b0}}, i_factor};
         end else if (i_speed == SPD_SLOW && ({1'b0, i_phase} != (i_factor - 4'd1))) begin
            // Repeat the same sample until the phase reaches factor-1.
            o_next_addr  = {1'b0, i_addr};
            o_next_phase = i_phase + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/recorder_sequencer.sv
`default_nettype none
// =============================================================================
// Module : recorder_sequencer
// Record/play/pause transport FSM driving a single-outstanding SRAM handshake.
// Rev    : 1.0
// =============================================================================
module recorder_sequencer
   import RecorderPkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [15:0]       i_event,
   input  logic              i_event_valid,
   input  logic              i_sample_tick,
   output logic              o_sram_req,
   output logic              o_sram_we,
   output logic [ADDR_W-1:0] o_addr,
   input  logic              i_sram_ack,
   output logic [1:0]        o_state,
   output logic [1:0]        o_speed,
   output logic [3:0]        o_factor,
   output logic [2:0]        o_slow_phase,
   output logic              o_interpol,
   output logic              o_done,
   output logic              o_overrun
);

   state_e            r_state, w_state, r_resume, w_resume;
   speed_e            r_speed, w_speed, w_ev_speed;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [ADDR_W:0]   r_end, w_end, w_step_addr;
   logic [3:0]        r_factor, w_factor, w_ev_factor, w_code;
   logic [2:0]        r_phase, w_phase, w_step_phase;
   logic              r_req, w_req, r_we, w_we, r_interpol, w_interpol;
   logic              r_done, w_done, r_overrun, w_overrun;
   logic              r_pend_stop, w_pend_stop, r_pend_pause, w_pend_pause;
   logic              w_ev_interpol, w_unused;

   assign w_code        = i_event[c_ev_code_msb:c_ev_code_lsb];
   assign w_ev_speed    = decode_speed(i_event[c_ev_speed_msb:c_ev_speed_lsb]);
   assign w_ev_factor   = decode_factor(i_event[c_ev_param_lsb+2:c_ev_param_lsb]);
   assign w_ev_interpol = i_event[c_ev_interpol];
   assign w_unused      = ^{i_event[c_ev_param_msb], i_event[4:0]};

   recorder_addr_step u_addr_step (
      .i_play       (r_state == ST_PLAY),
      .i_addr       (r_addr),
      .i_speed      (r_speed),
      .i_factor     (r_factor),
      .i_phase      (r_phase),
      .o_next_addr  (w_step_addr),
      .o_next_phase (w_step_phase)
   );

   // Evaluation order within a cycle: ack completion, then event, then tick.
   always_comb begin
      w_state      = r_state;
      w_resume     = r_resume;
      w_speed      = r_speed;
      w_addr       = r_addr;
      w_end        = r_end;
      w_factor     = r_factor;
      w_phase      = r_phase;
      w_req        = r_req;
      w_we         = r_we;
      w_interpol   = r_interpol;
      w_pend_stop  = r_pend_stop;
      w_pend_pause = r_pend_pause;
      w_done       = 1'b0;
      w_overrun    = 1'b0;

      if (r_req && i_sram_ack) begin
         w_req        = 1'b0;
         w_we         = 1'b0;
         w_pend_stop  = 1'b0;
         w_pend_pause = 1'b0;
         w_phase      = w_step_phase;
         if (r_state == ST_RECORD) begin
            w_addr = w_step_addr[ADDR_W-1:0];
            w_end  = w_step_addr;
            if (w_step_addr[ADDR_W]) begin
               w_done  = 1'b1;
               w_state = ST_IDLE;
            end
         end else if (w_step_addr >= r_end) begin
            w_addr  = '0;
            w_done  = 1'b1;
            w_state = ST_IDLE;
         end else begin
            w_addr = w_step_addr[ADDR_W-1:0];
         end
         // A STOP/PAUSE that arrived mid-handshake takes effect now.
         if (w_state != ST_IDLE) begin
            if (r_pend_stop) begin
               w_state = ST_IDLE;
            end else if (r_pend_pause) begin
               w_resume = r_state;
               w_state  = ST_PAUSE;
            end
         end
      end

      if (i_event_valid) begin
         if (w_state != ST_RECORD) begin
            w_speed    = w_ev_speed;
            w_factor   = w_ev_factor;
            w_interpol = w_ev_interpol;
            if (w_ev_speed != r_speed || w_ev_factor != r_factor) w_phase = 3'd0;
         end
         case (w_state)
            ST_IDLE: begin
               if (w_code == CODE_RECORD) begin
                  w_state = ST_RECORD;
                  w_addr  = '0;
                  w_end   = '0;
                  w_phase = 3'd0;
               end else if (w_code == CODE_PLAY && w_end != '0) begin
                  w_state = ST_PLAY;
                  w_addr  = '0;
                  w_phase = 3'd0;
               end
            end
            ST_PLAY, ST_RECORD: begin
               if (w_code == CODE_STOP) begin
                  if (w_req) w_pend_stop = 1'b1;
                  else       w_state     = ST_IDLE;
               end else if (w_code == CODE_PAUSE) begin
                  if (w_req) begin
                     w_pend_pause = 1'b1;
                  end else begin
                     w_resume = w_state;
                     w_state  = ST_PAUSE;
                  end
               end
            end
            default: begin
               if (w_code == CODE_STOP) begin
                  w_state = ST_IDLE;
               end else if ((w_code == CODE_PLAY && w_resume == ST_PLAY) ||
                            (w_code == CODE_RECORD && w_resume == ST_RECORD)) begin
                  w_state = w_resume;
               end
            end
         endcase
      end

      if (i_sample_tick) begin
         if (r_req) begin
            w_overrun = 1'b1;
         end else if (w_state == ST_PLAY || w_state == ST_RECORD) begin
            w_req = 1'b1;
            w_we  = (w_state == ST_RECORD);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_resume     <= ST_PLAY;
         r_speed      <= SPD_NORMAL;
         r_addr       <= '0;
         r_end        <= '0;
         r_factor     <= 4'd1;
         r_phase      <= 3'd0;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_interpol   <= 1'b0;
         r_done       <= 1'b0;
         r_overrun    <= 1'b0;
         r_pend_stop  <= 1'b0;
         r_pend_pause <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_resume     <= w_resume;
         r_speed      <= w_speed;
         r_addr       <= w_addr;
         r_end        <= w_end;
         r_factor     <= w_factor;
         r_phase      <= w_phase;
         r_req        <= w_req;
         r_we         <= w_we;
         r_interpol   <= w_interpol;
         r_done       <= w_done;
         r_overrun    <= w_overrun;
         r_pend_stop  <= w_pend_stop;
         r_pend_pause <= w_pend_pause;
      end
   end

   assign o_sram_req   = r_req;
   assign o_sram_we    = r_we;
   assign o_addr       = r_addr;
   assign o_state      = r_state;
   assign o_speed      = r_speed;
   assign o_factor     = r_factor;
   assign o_slow_phase = r_phase;
   assign o_interpol   = r_interpol;
   assign o_done       = r_done;
   assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_recorder_sequencer.sv
`default_nettype none
// =============================================================================
// Module : tb_recorder_sequencer
// Directed and randomized transport scenarios against a transaction-level model.
// Rev    : 1.0
// =============================================================================
module tb_recorder_sequencer;

   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_REC = 3;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [15:0] i_event = '0;
   logic        i_event_valid = 1'b0;
   logic        i_sample_tick = 1'b0;
   logic        i_sram_ack = 1'b0;
   logic        o_sram_req, o_sram_we, o_interpol, o_done, o_overrun;
   logic [19:0] o_addr;
   logic [1:0]  o_state, o_speed;
   logic [3:0]  o_factor;
   logic [2:0]  o_slow_phase;

   int total = 0;
   int bad   = 0;
   int m_state, m_paused, m_end, m_spd, m_fac, m_int;

   always #5 i_clk = ~i_clk;

   recorder_sequencer dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_event       (i_event),
      .i_event_valid (i_event_valid),
      .i_sample_tick (i_sample_tick),
      .o_sram_req    (o_sram_req),
      .o_sram_we     (o_sram_we),
      .o_addr        (o_addr),
      .i_sram_ack    (i_sram_ack),
      .o_state       (o_state),
      .o_speed       (o_speed),
      .o_factor      (o_factor),
      .o_slow_phase  (o_slow_phase),
      .o_interpol    (o_interpol),
      .o_done        (o_done),
      .o_overrun     (o_overrun)
   );

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_event(input int code, input int spd, input int prm, input int itp);
      i_event       = {4'(code), 2'(spd), 4'(prm), 1'(itp), 5'($urandom)};
      i_event_valid = 1'b1;
      step();
      i_event_valid = 1'b0;
      i_event       = 16'($urandom);
   endtask

   // Apply the transport rules to the model, then compare the visible state.
   task automatic send_event(input int code, input int spd, input int prm, input int itp);
      drive_event(code, spd, prm, itp);
      if (m_state != M_REC) begin
         m_spd = (spd == 3) ? 0 : spd;
         m_fac = (prm % 8) + 1;
         m_int = itp;
      end
      case (m_state)
         M_IDLE: begin
            if (code == 4) begin
               m_state = M_REC;
               m_end   = 0;
            end else if (code == 1 && m_end != 0) begin
               m_state = M_PLAY;
            end
         end
         M_PLAY, M_REC: begin
            if (code == 3) begin
               m_state = M_IDLE;
            end else if (code == 2) begin
               m_paused = m_state;
               m_state  = M_PAUSE;
            end
         end
         default: begin
            if (code == 3) m_state = M_IDLE;
            else if ((code == 1 && m_paused == M_PLAY) || (code == 4 && m_paused == M_REC))
               m_state = m_paused;
         end
      endcase
      chk("ev_state", o_state, m_state);
      chk("ev_speed", o_speed, m_spd);
      chk("ev_factor", o_factor, m_fac);
      chk("ev_interpol", o_interpol, m_int);
   endtask

   // One tick-initiated access: request, hold for lat cycles (optional dropped tick), ack.
   task automatic xfer(input int ea, input int ew, input int eph, input int lat_in, input bit ovr);
      int lat;
      lat = (ovr && lat_in < 1) ? 1 : lat_in;
      chk("pre_req", o_sram_req, 0);
      repeat ($urandom_range(0, 2)) step();
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      chk("req", o_sram_req, 1);
      chk("we", o_sram_we, ew);
      chk("addr", o_addr, ea);
      chk("phase", o_slow_phase, eph);
      for (int i = 0; i < lat; i++) begin
         if (ovr && i == 0) i_sample_tick = 1'b1;
         step();
         i_sample_tick = 1'b0;
         chk("hold_req", o_sram_req, 1);
         chk("hold_addr", o_addr, ea);
         chk("hold_we", o_sram_we, ew);
         chk("overrun", o_overrun, (ovr && i == 0));
      end
      i_sram_ack = 1'b1;
      step();
      i_sram_ack = 1'b0;
      chk("ack_req", o_sram_req, 0);
      chk("ack_overrun", o_overrun, 0);
   endtask

   task automatic rec_run(input int n, input int fixed_lat, input int ovr_pct);
      int spd;
      spd = $urandom_range(0, 2);
      if (spd == 2) spd = 3;
      send_event(4, spd, $urandom_range(0, 15), $urandom_range(0, 1));
      chk("rec_addr0", o_addr, 0);
      for (int k = 0; k < n; k++) begin
         xfer(k, 1, 0, (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3),
              ($urandom_range(0, 99) < ovr_pct));
         chk("rec_addr_inc", o_addr, k + 1);
         chk("rec_nodone", o_done, 0);
         m_end = k + 1;
      end
      send_event(3, 0, 0, 0);
   endtask

   // Expected read list derived from the recorded length and speed rules.
   task automatic play_run(input int spd, input int prm, input int itp, input int ovr_pct,
                           input int pause_pct);
      int qa[$];
      int qp[$];
      send_event(1, spd, prm, itp);
      chk("play_addr0", o_addr, 0);
      chk("play_phase0", o_slow_phase, 0);
      if (m_spd == 1) begin
         for (int a = 0; a < m_end; a += m_fac) begin qa.push_back(a); qp.push_back(0); end
      end else if (m_spd == 2) begin
         for (int a = 0; a < m_end; a++)
            for (int p = 0; p < m_fac; p++) begin qa.push_back(a); qp.push_back(p); end
      end else begin
         for (int a = 0; a < m_end; a++) begin qa.push_back(a); qp.push_back(0); end
      end
      for (int k = 0; k < qa.size(); k++) begin
         xfer(qa[k], 0, qp[k], $urandom_range(0, 3), ($urandom_range(0, 99) < ovr_pct));
         if (k == qa.size() - 1) begin
            chk("play_done", o_done, 1);
            chk("play_end_state", o_state, M_IDLE);
            chk("play_end_addr", o_addr, 0);
            m_state = M_IDLE;
            step();
            chk("done_pulse", o_done, 0);
         end else begin
            chk("play_nodone", o_done, 0);
            chk("play_next_addr", o_addr, qa[k+1]);
            chk("play_next_phase", o_slow_phase, qp[k+1]);
            if ($urandom_range(0, 99) < pause_pct) begin
               send_event(2, spd, prm, itp);
               i_sample_tick = 1'b1;
               step();
               i_sample_tick = 1'b0;
               chk("pause_noreq", o_sram_req, 0);
               send_event(4, spd, prm, itp);
               send_event(1, spd, prm, itp);
               chk("resume_addr", o_addr, qa[k+1]);
               chk("resume_phase", o_slow_phase, qp[k+1]);
            end
         end
      end
   endtask

   initial begin
      m_state = M_IDLE; m_paused = M_PLAY; m_end = 0; m_spd = 0; m_fac = 1; m_int = 0;
      step();
      step();
      chk("rst_state", o_state, M_IDLE);
      chk("rst_addr", o_addr, 0);
      chk("rst_req", o_sram_req, 0);
      chk("rst_we", o_sram_we, 0);
      chk("rst_speed", o_speed, 0);
      chk("rst_factor", o_factor, 1);
      chk("rst_phase", o_slow_phase, 0);
      chk("rst_interpol", o_interpol, 0);
      chk("rst_done", o_done, 0);
      chk("rst_overrun", o_overrun, 0);
      i_rst = 1'b1;
      step();

      // Nothing recorded yet: PLAY is ignored and ticks do nothing.
      send_event(1, 0, 0, 0);
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      chk("empty_play_noreq", o_sram_req, 0);

      rec_run(5, 2, 0);
      play_run(0, 0, 0, 0, 0);
      rec_run(10, -1, 25);
      play_run(1, 2, 1, 0, 0);
      play_run(2, 1, 0, 0, 0);

      // Dropped tick, then STOP while the read is outstanding.
      send_event(1, 0, 0, 0);
      i_sample_tick = 1'b1;
      step();
      chk("ovr_req", o_sram_req, 1);
      step();
      i_sample_tick = 1'b0;
      chk("ovr_pulse", o_overrun, 1);
      chk("ovr_req_held", o_sram_req, 1);
      drive_event(3, 0, 0, 0);
      chk("stop_req_held", o_sram_req, 1);
      chk("stop_state_held", o_state, M_PLAY);
      chk("stop_overrun_clr", o_overrun, 0);
      step();
      chk("stop_req_held2", o_sram_req, 1);
      i_sram_ack = 1'b1;
      step();
      i_sram_ack = 1'b0;
      chk("stop_ack_req", o_sram_req, 0);
      chk("stop_ack_state", o_state, M_IDLE);
      chk("stop_ack_addr", o_addr, 1);
      m_state = M_IDLE;

      // Pause/resume keeps the play position; RECORD cannot resume a paused play.
      send_event(1, 0, 0, 0);
      xfer(0, 0, 0, 1, 0);
      xfer(1, 0, 0, 0, 0);
      send_event(2, 0, 0, 0);
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      chk("paused_noreq", o_sram_req, 0);
      send_event(4, 0, 0, 0);
      send_event(1, 0, 0, 0);
      chk("resumed_addr", o_addr, 2);
      xfer(2, 0, 0, 1, 0);
      chk("resumed_next", o_addr, 3);
      send_event(3, 0, 0, 0);

      for (int r = 0; r < 6; r++) begin
         rec_run($urandom_range(1, 12), -1, 25);
         play_run($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1), 20, 15);
      end

      // Event and tick together: RECORD applies first, so the tick writes address 0.
      i_event       = {4'd4, 2'd0, 4'd0, 1'b0, 5'd0};
      i_event_valid = 1'b1;
      i_sample_tick = 1'b1;
      step();
      i_event_valid = 1'b0;
      i_sample_tick = 1'b0;
      chk("same_cycle_state", o_state, M_REC);
      chk("same_cycle_req", o_sram_req, 1);
      chk("same_cycle_we", o_sram_we, 1);
      chk("same_cycle_addr", o_addr, 0);
      step();
      chk("pre_rst_req", o_sram_req, 1);
      #2 i_rst = 1'b0;
      #1;
      chk("arst_state", o_state, M_IDLE);
      chk("arst_req", o_sram_req, 0);
      chk("arst_we", o_sram_we, 0);
      chk("arst_addr", o_addr, 0);
      chk("arst_speed", o_speed, 0);
      chk("arst_factor", o_factor, 1);
      chk("arst_phase", o_slow_phase, 0);
      chk("arst_interpol", o_interpol, 0);
      chk("arst_done", o_done, 0);
      chk("arst_overrun", o_overrun, 0);
      step();
      i_rst = 1'b1;
      step();
      chk("post_rst_req", o_sram_req, 0);
      m_state = M_IDLE; m_end = 0; m_spd = 0; m_fac = 1; m_int = 0;
      send_event(1, 0, 0, 0);
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
      chk("post_rst_noreq", o_sram_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
